// File: rtl/itof_pipe.sv
// rtl/itof_pipe.sv - three-stage signed int32 to IEEE-754 single converter
// Stages: absolute value, normalise, round and pack; one global stall enable.
module itof_pipe #(
   parameter int ROUND_MODE = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] x,
   input  logic        x_valid,
   output logic        x_ready,
   output logic [31:0] y,
   output logic        y_valid,
   input  logic        y_ready
);

   logic        en;

   logic        v1_q, s1_q;
   logic [31:0] m1_q;
   logic [31:0] m1_d;

   logic        v2_q, s2_q;
   logic [4:0]  lz2_q;
   logic [31:0] n2_q;
   logic [4:0]  lz_d;
   logic [31:0] n2_d;

   logic        v3_q;
   logic [31:0] y_q;
   logic [31:0] y_d;

   logic [22:0] frac;
   logic        g_bit, s_bit, l_bit, inc;
   logic [23:0] sum;
   logic [7:0]  exp_c;

   assign en      = ~v3_q | y_ready;
   assign x_ready = en;
   assign y       = y_q;
   assign y_valid = v3_q;

   assign m1_d = x[31] ? (~x + 32'd1) : x;

   // Highest set bit wins; an all-zero operand leaves lz at 0 and normalises to 0.
   always_comb begin
      lz_d = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (m1_q[i]) lz_d = 5'(31 - i);
      end
      n2_d = m1_q << lz_d;
   end

   // n2_q[31] is set exactly when the operand was non-zero.
   always_comb begin
      frac  = n2_q[30:8];
      g_bit = n2_q[7];
      s_bit = |n2_q[6:0];
      l_bit = n2_q[8];
      inc   = (ROUND_MODE == 0) ? (g_bit & (s_bit | l_bit)) : 1'b0;
      sum   = {1'b0, frac} + {23'd0, inc};
      exp_c = 8'd158 - {3'd0, lz2_q} + {7'd0, sum[23]};
      y_d   = n2_q[31] ? {s2_q, exp_c, sum[22:0]} : 32'h0000_0000;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_q  <= 1'b0;
         s1_q  <= 1'b0;
         m1_q  <= 32'd0;
         v2_q  <= 1'b0;
         s2_q  <= 1'b0;
         lz2_q <= 5'd0;
         n2_q  <= 32'd0;
         v3_q  <= 1'b0;
         y_q   <= 32'd0;
      end else if (en) begin
         v1_q  <= x_valid;
         s1_q  <= x[31];
         m1_q  <= m1_d;
         v2_q  <= v1_q;
         s2_q  <= s1_q;
         lz2_q <= lz_d;
         n2_q  <= n2_d;
         v3_q  <= v2_q;
         y_q   <= y_d;
      end
   end

endmodule

// File: tb/tb_itof_pipe.sv
// tb/tb_itof_pipe.sv - randomized scoreboard bench for itof_pipe in both rounding modes
// Two instances share stimulus; a queue of accepted operands feeds an arithmetic model.
module tb_itof_pipe;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] x;
   logic        x_valid;
   logic        y_ready;
   logic        x_ready0, x_ready1;
   logic [31:0] y0, y1;
   logic        y_valid0, y_valid1;

   int checks = 0;
   int failures = 0;
   int emitted = 0;
   logic [31:0] q[$];
   logic        stall_prev = 1'b0;
   logic [31:0] y_prev = 32'd0;

   always #5 clk = ~clk;

   itof_pipe #(.ROUND_MODE(0)) dut0 (
      .clk(clk), .rstn(rstn), .x(x), .x_valid(x_valid), .x_ready(x_ready0),
      .y(y0), .y_valid(y_valid0), .y_ready(y_ready)
   );

   itof_pipe #(.ROUND_MODE(1)) dut1 (
      .clk(clk), .rstn(rstn), .x(x), .x_valid(x_valid), .x_ready(x_ready1),
      .y(y1), .y_valid(y_valid1), .y_ready(y_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference (float)x: locate the leading one, then round on the discarded remainder.
   function automatic logic [31:0] model(input logic [31:0] xi, input int mode);
      longint xu, m, qq, rem, half;
      int e, sh;
      logic sg;
      if (xi == 32'd0) return 32'd0;
      sg = xi[31];
      xu = longint'({32'd0, xi});
      m  = sg ? (64'sd4294967296 - xu) : xu;
      e  = 0;
      while ((m >> (e + 1)) != 0) e++;
      if (e <= 23) begin
         qq = m << (23 - e);
      end else begin
         sh   = e - 23;
         qq   = m >> sh;
         rem  = m - (qq << sh);
         half = longint'(1) << (sh - 1);
         if (mode == 0 && (rem > half || (rem == half && qq[0]))) qq++;
         if (qq == (longint'(1) << 24)) begin
            qq = qq >> 1;
            e++;
         end
      end
      return {sg, 8'(e + 127), qq[22:0]};
   endfunction

   function automatic logic [31:0] rand_x();
      case ($urandom_range(0, 4))
         0: return $urandom >> $urandom_range(0, 31);
         1: return -($urandom >> $urandom_range(0, 31));
         2: return (32'd1 << $urandom_range(0, 31)) + $urandom_range(0, 3) - 32'd1;
         3: return 32'($urandom_range(0, 8)) - 32'd4;
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rstn) begin
         q.delete();
         stall_prev = 1'b0;
         check("rst_y_valid", {31'd0, y_valid0}, 32'd0);
         check("rst_y", y0, 32'd0);
      end else begin
         check("x_ready_rule", {31'd0, x_ready0}, {31'd0, ~y_valid0 | y_ready});
         check("mode_valid_match", {31'd0, y_valid1}, {31'd0, y_valid0});
         if (stall_prev) begin
            check("stall_hold_valid", {31'd0, y_valid0}, 32'd1);
            check("stall_hold_y", y0, y_prev);
         end
         if (y_valid0 && y_ready) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_output actual=%h required=none", y0);
            end else begin
               logic [31:0] xe;
               xe = q.pop_front();
               check("result_rne", y0, model(xe, 0));
               check("result_rtz", y1, model(xe, 1));
               emitted++;
            end
         end
         if (x_valid && x_ready0) q.push_back(x);
         stall_prev = y_valid0 && !y_ready;
         y_prev     = y0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one operand, require y_valid exactly three edges later with the given results.
   task automatic send_one(input logic [31:0] xi, input logic [31:0] e0, input logic [31:0] e1);
      int n;
      x       = xi;
      x_valid = 1'b1;
      n       = 0;
      step();
      n++;
      x_valid = 1'b0;
      while (!y_valid0 && n < 10) begin
         step();
         n++;
      end
      check("latency", 32'(n), 32'd3);
      check("direct_rne", y0, e0);
      check("direct_rtz", y1, e1);
   endtask

   initial begin
      rstn    = 1'b0;
      x       = 32'd0;
      x_valid = 1'b0;
      y_ready = 1'b1;

      check("model_one", model(32'd1, 0), 32'h3F80_0000);
      check("model_max_rne", model(32'h7FFF_FFFF, 0), 32'h4F00_0000);
      check("model_max_rtz", model(32'h7FFF_FFFF, 1), 32'h4EFF_FFFF);
      check("model_tie_up", model(32'h0100_0003, 0), 32'h4B80_0002);

      repeat (3) step();
      check("reset_y_valid", {31'd0, y_valid0}, 32'd0);
      check("reset_y", y0, 32'd0);
      check("reset_x_ready", {31'd0, x_ready0}, 32'd1);
      rstn = 1'b1;
      step();

      send_one(32'd1,          32'h3F80_0000, 32'h3F80_0000);
      send_one(32'hFFFF_FFFF,  32'hBF80_0000, 32'hBF80_0000);
      send_one(32'd0,          32'h0000_0000, 32'h0000_0000);
      send_one(32'h8000_0000,  32'hCF00_0000, 32'hCF00_0000);
      send_one(32'h7FFF_FFFF,  32'h4F00_0000, 32'h4EFF_FFFF);
      send_one(32'h0100_0001,  32'h4B80_0000, 32'h4B80_0000);
      send_one(32'h0100_0003,  32'h4B80_0002, 32'h4B80_0001);
      send_one(32'h0100_0002,  32'h4B80_0001, 32'h4B80_0001);
      step();

      // Backpressure: x = 1..8 back-to-back, y_ready low for cycles 5..8.
      begin
         int k, base;
         logic acc;
         k    = 1;
         base = emitted;
         for (int cyc = 0; cyc < 24; cyc++) begin
            y_ready = !(cyc >= 5 && cyc <= 8);
            x_valid = (k <= 8);
            x       = 32'(k);
            #1;
            if (cyc == 5) check("x_ready_falls", {31'd0, x_ready0}, 32'd0);
            acc = x_valid && x_ready0;
            step();
            if (acc) k++;
         end
         x_valid = 1'b0;
         y_ready = 1'b1;
         repeat (4) step();
         check("bp_count", 32'(emitted - base), 32'd8);
      end

      // Reset with three results in flight.
      for (int i = 0; i < 3; i++) begin
         x       = 32'(100 + i);
         x_valid = 1'b1;
         step();
      end
      x_valid = 1'b0;
      #1;
      rstn = 1'b0;
      #1;
      check("async_y_valid", {31'd0, y_valid0}, 32'd0);
      check("async_y", y0, 32'd0);
      step();
      step();
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("no_stale", {31'd0, y_valid0}, 32'd0);
      end
      send_one(32'd5, 32'h40A0_0000, 32'h40A0_0000);
      step();

      // Random traffic under random valid/ready.
      for (int cyc = 0; cyc < 40000; cyc++) begin
         x       = rand_x();
         x_valid = ($urandom_range(0, 3) != 0);
         y_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      x_valid = 1'b0;
      y_ready = 1'b1;
      repeat (8) step();
      check("drained", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
